// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared widths and FSM encodings for the memory controller
package mem_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int CNT_WIDTH      = 4;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - request/response bundle between MDR side and mem_ctrl
interface mem_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  busy;
  logic                  done;
  logic                  mdr_load;
  logic                  req_drop;

  modport master (
    output req, we, addr, wr_data,
    input  rd_data, busy, done, mdr_load, req_drop
  );

  modport slave (
    input  req, we, addr, wr_data,
    output rd_data, busy, done, mdr_load, req_drop
  );

endinterface

// File: rtl/mem_ctrl_sp_ram.sv
// rtl/mem_ctrl_sp_ram.sv - single-port synchronous RAM, registered read, no reset
module mem_ctrl_sp_ram
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // rdata only moves on a read access, so it holds between reads
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - request FSM with wait-state counter wrapped around the RAM
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int WAIT_STATES = 1
) (
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(WAIT_STATES);

  state_t                 state;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wr_data_q;
  logic                   we_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   load_q;
  logic                   drop_q;
  logic                   rd_valid;
  logic                   access;
  logic [DATA_WIDTH-1:0]  ram_rdata;

  assign access = (state == ST_WAIT) && (cnt == '0);

  mem_ctrl_sp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .en    (access),
    .we    (we_q),
    .addr  (addr_q),
    .wdata (wr_data_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wr_data_q <= '0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      load_q    <= 1'b0;
      drop_q    <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      load_q <= 1'b0;
      if (bus.req && (state != ST_IDLE)) begin
        drop_q <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            addr_q    <= bus.addr;
            wr_data_q <= bus.wr_data;
            we_q      <= bus.we;
            cnt       <= CNT_INIT;
            busy_q    <= 1'b1;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            done_q <= 1'b1;
            load_q <= ~we_q;
            if (!we_q) begin
              rd_valid <= 1'b1;
            end
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  // RAM read register has no reset; mask it to zero until the first read lands
  assign bus.rd_data  = rd_valid ? ram_rdata : '0;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.mdr_load = load_q;
  assign bus.req_drop = drop_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl
module tb_mem_ctrl;

  localparam int WS1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mem_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) if1 ();
  mem_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) if0 ();

  mem_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_STATES(WS1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  mem_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_STATES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] ref_mem [256];
  logic [7:0] last_rd = 8'h00;
  bit         chk_on = 1'b1;
  vec_t       vt [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_c(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (chk_on) chk(nm, act, exp);
  endtask

  // Starts at posedge+1 with the FSM idle; returns at posedge+1 with it idle again.
  // mode 0 normal, 1 disturb inputs while busy, 2 inject a request while busy
  task automatic txn(input logic w, input logic [7:0] a, input logic [7:0] d, input int mode);
    int k;
    if1.req = 1'b1; if1.we = w; if1.addr = a; if1.wr_data = d;
    @(posedge clk); #1;
    if1.req = 1'b0;
    chk_c("busy_rise", if1.busy, 1);
    if (mode == 1) begin
      if1.addr = a + 8'd1; if1.wr_data = 8'h99;
    end else if (mode == 2) begin
      if1.req = 1'b1; if1.we = 1'b1; if1.addr = a + 8'd1; if1.wr_data = 8'hFF;
    end
    k = 0;
    while (if1.done !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      if1.req = 1'b0;
      k++;
    end
    if (w) ref_mem[a] = d;
    else   last_rd = ref_mem[a];
    chk_c("latency", k, WS1 + 1);
    chk_c("mdr_load", if1.mdr_load, {31'd0, ~w});
    chk_c("rd_data", if1.rd_data, last_rd);
    chk_c("busy_in_done", if1.busy, 1);
    @(posedge clk); #1;
    chk_c("done_fall", if1.done, 0);
    chk_c("load_fall", if1.mdr_load, 0);
    chk_c("busy_fall", if1.busy, 0);
    chk_c("rd_hold", if1.rd_data, last_rd);
  endtask

  initial begin
    int k;
    vt[0] = '{1'b1, 8'h10, 8'hC3, 8'h00};
    vt[1] = '{1'b0, 8'h10, 8'h00, 8'hC3};
    vt[2] = '{1'b1, 8'h00, 8'h00, 8'h00};
    vt[3] = '{1'b1, 8'hFF, 8'hFF, 8'h00};
    vt[4] = '{1'b0, 8'hFF, 8'h00, 8'hFF};
    vt[5] = '{1'b0, 8'h00, 8'h00, 8'h00};

    if1.req = 1'b0; if1.we = 1'b0; if1.addr = '0; if1.wr_data = '0;
    if0.req = 1'b0; if0.we = 1'b0; if0.addr = '0; if0.wr_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_rd_data", if1.rd_data, 0);
    chk("rst_busy", if1.busy, 0);
    chk("rst_done", if1.done, 0);
    chk("rst_drop", if1.req_drop, 0);

    // Zero wait states: write then read on dut0
    if0.req = 1'b1; if0.we = 1'b1; if0.addr = 8'h07; if0.wr_data = 8'h5A;
    @(posedge clk); #1 if0.req = 1'b0;
    chk("ws0_wr_busy", if0.busy, 1);
    @(posedge clk); #1;
    chk("ws0_wr_done", if0.done, 1);
    chk("ws0_wr_load", if0.mdr_load, 0);
    @(posedge clk); #1;
    chk("ws0_wr_idle", if0.busy, 0);
    if0.req = 1'b1; if0.we = 1'b0; if0.addr = 8'h07;
    @(posedge clk); #1 if0.req = 1'b0;
    chk("ws0_rd_busy", if0.busy, 1);
    chk("ws0_rd_nodone", if0.done, 0);
    chk("ws0_rd_old", if0.rd_data, 0);
    @(posedge clk); #1;
    chk("ws0_rd_data", if0.rd_data, 8'h5A);
    chk("ws0_rd_done", if0.done, 1);
    chk("ws0_rd_load", if0.mdr_load, 1);
    @(posedge clk); #1;
    chk("ws0_done_fall", if0.done, 0);
    chk("ws0_busy_fall", if0.busy, 0);
    chk("ws0_rd_hold", if0.rd_data, 8'h5A);

    // Fill dut1 RAM so the model knows every location
    chk_on = 1'b0;
    for (int i = 0; i < 256; i++) txn(1'b1, i[7:0], 8'($urandom), 0);
    chk_on = 1'b1;

    for (int i = 0; i < 6; i++) begin
      txn(vt[i].we, vt[i].addr, vt[i].wdata, 0);
      if (!vt[i].we) chk("vec_rd", if1.rd_data, vt[i].exp_rd);
    end

    // Input stability while busy
    txn(1'b1, 8'h20, 8'h66, 1);
    txn(1'b0, 8'h20, 8'h00, 0);
    chk("stab_20", if1.rd_data, 8'h66);
    txn(1'b0, 8'h21, 8'h00, 0);

    // Dropped request
    chk("drop_pre", if1.req_drop, 0);
    txn(1'b1, 8'h40, 8'h3C, 2);
    chk("drop_set", if1.req_drop, 1);
    txn(1'b0, 8'h41, 8'h00, 0);
    txn(1'b0, 8'h40, 8'h00, 0);
    chk("drop_40", if1.rd_data, 8'h3C);
    chk("drop_sticky", if1.req_drop, 1);

    for (int i = 0; i < 60; i++) begin
      txn(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 0);
    end
    chk("drop_sticky2", if1.req_drop, 1);

    // Async reset mid-cycle during a read's done pulse
    if1.req = 1'b1; if1.we = 1'b0; if1.addr = 8'h10;
    @(posedge clk); #1 if1.req = 1'b0;
    k = 0;
    while (if1.done !== 1'b1 && k < 20) begin
      @(posedge clk); #1; k++;
    end
    chk("pre_rst_done", if1.done, 1);
    #2;
    if1.we = 1'($urandom); if1.addr = 8'($urandom); if1.wr_data = 8'($urandom);
    rst = 1'b1;
    #1;
    chk("arst_rd_data", if1.rd_data, 0);
    chk("arst_busy", if1.busy, 0);
    chk("arst_done", if1.done, 0);
    chk("arst_load", if1.mdr_load, 0);
    chk("arst_drop", if1.req_drop, 0);
    if1.req = 1'b1;
    @(posedge clk); #1;
    chk("rst_wins", if1.busy, 0);
    rst = 1'b0; if1.req = 1'b0;
    last_rd = 8'h00;
    @(posedge clk); #1;
    chk("rst_wins_idle", if1.busy, 0);

    // Reset before the access edge of a write
    txn(1'b1, 8'h30, 8'h55, 0);
    if1.req = 1'b1; if1.we = 1'b1; if1.addr = 8'h30; if1.wr_data = 8'hAA;
    @(posedge clk); #1 if1.req = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    #1 chk("midwr_busy", if1.busy, 0);
    @(posedge clk); #1 rst = 1'b0;
    last_rd = 8'h00;
    txn(1'b0, 8'h30, 8'h00, 0);
    chk("midwr_keep", if1.rd_data, 8'h55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Memory controller and RAM stage that sits directly beside the MDR. It consumes the MDR's outgoing write data and produces the read data that the MDR loads on its memory input. It runs single-transaction read/write handshakes against an internal single-port synchronous RAM, with a configurable number of wait states. It also generates the load strobe the MDR uses to capture read data.

Parameters:
DATA_WIDTH, 8, word width; matches MDR DATA_WIDTH
ADDR_WIDTH, 8, address width; RAM depth = 2**ADDR_WIDTH
WAIT_STATES, 1, extra access cycles, legal range 0..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req  in  1  transaction request, single-cycle pulse by protocol
we  in  1  1 = write, 0 = read; sampled with req
addr  in  ADDR_WIDTH  address from MAR; sampled with req
wr_data  in  DATA_WIDTH  write data from MDR bus_data_out; sampled with req
rd_data  out  DATA_WIDTH  read data to MDR bus_data_in
busy  out  1  high while a transaction is in flight
done  out  1  one-cycle completion pulse (reads and writes)
mdr_load  out  1  one-cycle pulse, reads only, coincident with done; drives MDR mdr_en
req_drop  out  1  sticky flag: a req arrived while busy

Behaviour:
- Reset, asynchronous:
  - state = IDLE, wait counter = 0.
  - rd_data, busy, done, mdr_load, req_drop all = 0.
  - RAM contents are not cleared.
- FSM states are IDLE, WAIT, DONE. busy = (state != IDLE), registered.
- IDLE:
  - If req=1 at edge N, latch addr, we and wr_data into internal registers.
  - Load the counter with WAIT_STATES and go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If counter != 0, decrement it and stay.
  - If counter == 0, perform the access at this edge and go to DONE.
  - The access edge is therefore N+1+WAIT_STATES.
- Access:
  - Write: RAM[addr_q] <= wr_data_q. rd_data is unchanged.
  - Read: rd_data <= RAM[addr_q].
- DONE:
  - done=1 for exactly one cycle. mdr_load=1 in the same cycle if the transaction is a read.
  - The next edge returns the FSM to IDLE.
- Latency: done is high in the cycle following edge N+1+WAIT_STATES. A new request can be sampled at edge N+3+WAIT_STATES at the earliest.
- rd_data holds its value until the next read access; it stays valid after done falls.
- Changes on addr, we or wr_data while busy have no effect; the latched copies are used.
- req=1 while state != IDLE (including the DONE cycle):
  - The request is ignored and req_drop is set to 1.
  - req_drop stays set until reset.
  - The in-flight transaction is unaffected.
- Reset mid-transaction:
  - Aborts immediately and the FSM returns to IDLE.
  - A write whose access edge has not occurred leaves the RAM untouched.
  - A done or mdr_load pulse in progress is cleared.
- Counter width is 4 bits. WAIT_STATES = 0 gives a single WAIT cycle; there is no underflow.
- Simultaneous rst and req: rst wins; the request is discarded.

Decomposition:
- Shared header mem_defs.vh holds:
  - FSM state encodings: IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2.
  - Default DATA_WIDTH and ADDR_WIDTH, shared with mdr.
- One sub-module, sp_ram: single-port synchronous RAM with a write enable and a registered read port, no reset, same parameters.
- The mem_ctrl FSM, counter and latches wrap sp_ram.

Test Plan:
1. Reset: assert rst mid-cycle with random inputs. Required: rd_data=0x00; busy, done, mdr_load and req_drop all 0, immediately and without waiting for a clock edge.
2. Write then read (WAIT_STATES=1):
   - Write: req pulse, we=1, addr=0x10, wr_data=0xC3. Required: busy rises after the sampling edge N, done pulses in the cycle after edge N+2, mdr_load stays 0.
   - Read: req pulse, we=0, addr=0x10. Required: rd_data=0xC3 at edge N+2, done=1 and mdr_load=1 for one cycle.
3. Input stability:
   - Write 0x66 to addr 0x20. One cycle after the request edge, change addr to 0x21 and wr_data to 0x99.
   - Required: a read of 0x20 returns 0x66, and a read of 0x21 returns its prior content.
4. Dropped request:
   - During a busy write to 0x40, pulse req with we=1, addr=0x41, wr_data=0xFF.
   - Required: req_drop=1 and stays 1, RAM[0x41] unchanged, and the 0x40 write completes normally.
5. Reset mid-write:
   - Preload RAM[0x30]=0x55. Issue a write of 0xAA to 0x30, then assert rst during the WAIT cycle before the access edge.
   - Required: after release, a read of 0x30 returns 0x55.
6. Minimum latency (WAIT_STATES=0): a read request sampled at edge N gives rd_data updated at N+1, done and mdr_load high for the N+1..N+2 cycle, and busy low after N+2.
